// File: rtl/missile_hit_detect_if.sv
// Missile/formation geometry in, hit index and strobes out, for missile_hit_detect.
// The score signal exists only when ALIEN_SCORE_EN is defined.
interface missile_hit_detect_if #(
   parameter int NUM_COLS = 10,
   parameter int NUM_ROWS = 6
);
   logic                               frame_tick;
   logic                               missile_active;
   logic [9:0]                         missile_x;
   logic [9:0]                         missile_y;
   logic [9:0]                         formation_x;
   logic [9:0]                         formation_y;
   logic [NUM_COLS-1:0][NUM_ROWS-1:0]  alien_grid;
   logic [6:0]                         alien_hit;
   logic                               hit;
   logic                               missile_kill;
   logic                               busy;
`ifdef ALIEN_SCORE_EN
   logic [15:0]                        score;

   modport master (
      output frame_tick, missile_active, missile_x, missile_y,
             formation_x, formation_y, alien_grid,
      input  alien_hit, hit, missile_kill, busy, score
   );
   modport slave (
      input  frame_tick, missile_active, missile_x, missile_y,
             formation_x, formation_y, alien_grid,
      output alien_hit, hit, missile_kill, busy, score
   );
`else
   modport master (
      output frame_tick, missile_active, missile_x, missile_y,
             formation_x, formation_y, alien_grid,
      input  alien_hit, hit, missile_kill, busy
   );
   modport slave (
      input  frame_tick, missile_active, missile_x, missile_y,
             formation_x, formation_y, alien_grid,
      output alien_hit, hit, missile_kill, busy
   );
`endif
endinterface

// File: rtl/missile_hit_detect.sv
// Once per frame maps the missile pixel onto the alien formation by repeated subtraction and
// strobes a hit for a live alien; optional score counter under ALIEN_SCORE_EN.
module missile_hit_detect #(
   parameter int NUM_COLS = 10,
   parameter int NUM_ROWS = 6,
   parameter int PITCH_X  = 32,
   parameter int PITCH_Y  = 24,
   parameter int SPRITE_W = 24,
   parameter int SPRITE_H = 16
) (
   input logic                 Clk,
   input logic                 Reset,
   missile_hit_detect_if.slave bus
);
   typedef enum logic [2:0] {IDLE, CAPTURE, DIV_X, DIV_Y, LOOKUP, HIT, HOLD} state_t;

   localparam logic [10:0] PX       = 11'(PITCH_X);
   localparam logic [10:0] PY       = 11'(PITCH_Y);
   localparam logic [10:0] SW       = 11'(SPRITE_W);
   localparam logic [10:0] SH       = 11'(SPRITE_H);
   localparam logic [3:0]  LAST_COL = 4'(NUM_COLS - 1);
   localparam logic [2:0]  LAST_ROW = 3'(NUM_ROWS - 1);

   state_t      r_state;
   logic [10:0] r_rem_x;
   logic [10:0] r_rem_y;
   logic [3:0]  r_col;
   logic [2:0]  r_row;
   logic [6:0]  r_alien_hit;
   logic        r_hit;
   logic        r_kill;
   logic        r_busy;

   logic [10:0] w_dx;
   logic [10:0] w_dy;
   logic        w_sprite_hit;

   // Two's-complement offsets; bit 10 set means the missile is left of / above the formation
   assign w_dx = {1'b0, bus.missile_x} - {1'b0, bus.formation_x};
   assign w_dy = {1'b0, bus.missile_y} - {1'b0, bus.formation_y};

   assign w_sprite_hit = (r_rem_x < SW) && (r_rem_y < SH) &&
                         bus.alien_grid[r_col][r_row] && bus.missile_active;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_rem_x     <= '0;
         r_rem_y     <= '0;
         r_col       <= '0;
         r_row       <= '0;
         r_alien_hit <= '0;
         r_hit       <= 1'b0;
         r_kill      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_hit  <= 1'b0;
         r_kill <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.frame_tick && bus.missile_active) begin
                  r_state <= CAPTURE;
                  r_busy  <= 1'b1;
               end
            end
            CAPTURE: begin
               r_rem_x <= w_dx;
               r_rem_y <= w_dy;
               r_col   <= '0;
               r_row   <= '0;
               if (w_dx[10] || w_dy[10]) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= DIV_X;
               end
            end
            DIV_X: begin
               if (r_rem_x >= PX) begin
                  if (r_col == LAST_COL) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_rem_x <= r_rem_x - PX;
                     r_col   <= r_col + 4'd1;
                  end
               end else begin
                  r_state <= DIV_Y;
               end
            end
            DIV_Y: begin
               if (r_rem_y >= PY) begin
                  if (r_row == LAST_ROW) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_rem_y <= r_rem_y - PY;
                     r_row   <= r_row + 3'd1;
                  end
               end else begin
                  r_state <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (w_sprite_hit) begin
                  r_alien_hit <= {r_col, r_row};
                  r_hit       <= 1'b1;
                  r_kill      <= 1'b1;
                  r_state     <= HIT;
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            HIT: begin
               r_state <= HOLD;
               r_busy  <= 1'b0;
            end
            // One hit per missile: wait for the shot to be retired before re-arming
            HOLD: begin
               if (!bus.missile_active) r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.alien_hit    = r_alien_hit;
   assign bus.hit          = r_hit;
   assign bus.missile_kill = r_kill;
   assign bus.busy         = r_busy;

`ifdef ALIEN_SCORE_EN
   logic [15:0] r_score;
   logic [6:0]  w_pts;
   logic [16:0] w_score_sum;

   always_comb begin
      w_pts = 7'd10;
      if (r_row == 3'd0)      w_pts = 7'd30;
      else if (r_row <= 3'd2) w_pts = 7'd20;
   end

   assign w_score_sum = {1'b0, r_score} + 17'(w_pts);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)                r_score <= '0;
      else if (r_state == HIT)  r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
   end

   assign bus.score = r_score;
`endif
endmodule

// File: tb/tb_missile_hit_detect.sv
// Directed and randomized shots against an arithmetic model of the formation hit geometry.
module tb_missile_hit_detect;
   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   missile_hit_detect_if bus ();
   missile_hit_detect dut (.Clk(Clk), .Reset(Reset), .bus(bus));

   int n_cmp  = 0;
   int n_fail = 0;
   int fx, fy;
   bit m_hold;
   logic [6:0] m_last;
   int m_score;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference geometry: integer divide/modulo on pixel offsets
   function automatic void model(input int mx, input int my, input logic [9:0][5:0] grid,
                                 output bit h, output int lat, output logic [6:0] idx);
      int dx, dy, c, r;
      dx = mx - fx;
      dy = my - fy;
      h = 0; lat = 0; idx = '0;
      if (dx < 0 || dy < 0) return;
      c = dx / 32;
      r = dy / 24;
      if (c >= 10 || r >= 6) return;
      if ((dx % 32) >= 24 || (dy % 24) >= 16 || !grid[c][r]) return;
      h = 1;
      lat = 4 + c + r;
      idx = {c[3:0], r[2:0]};
   endfunction

   function automatic int points(input logic [6:0] idx);
      if (idx[2:0] == 3'd0) return 30;
      if (idx[2:0] <= 3'd2) return 20;
      return 10;
   endfunction

   task automatic set_formation(input int x, input int y);
      fx = x;
      fy = y;
      bus.formation_x = 10'(x);
      bus.formation_y = 10'(y);
   endtask

   task automatic shot(input string tag, input int mx, input int my);
      bit eh, seen;
      int el, k_hit;
      logic [6:0] ei;
      model(mx, my, bus.alien_grid, eh, el, ei);
      if (m_hold) eh = 0;
      bus.missile_x  = 10'(mx);
      bus.missile_y  = 10'(my);
      bus.frame_tick = 1'b1;
      @(posedge Clk); #1;
      bus.frame_tick = 1'b0;
      seen = 0;
      k_hit = 0;
      for (int k = 1; k <= 25 && !seen; k++) begin
         @(posedge Clk); #1;
         if (bus.hit) begin
            seen = 1;
            k_hit = k;
         end
      end
      check({tag, ".hit_seen"}, 32'(seen), 32'(eh));
      if (eh && seen) begin
         check({tag, ".latency"}, 32'(k_hit), 32'(el));
         check({tag, ".alien_hit"}, 32'(bus.alien_hit), 32'(ei));
         check({tag, ".kill"}, 32'(bus.missile_kill), 32'd1);
         check({tag, ".busy_hit"}, 32'(bus.busy), 32'd1);
         m_hold = 1;
         m_last = ei;
         m_score = m_score + points(ei);
         if (m_score > 65535) m_score = 65535;
         @(posedge Clk); #1;
         check({tag, ".hit_pulse"}, 32'(bus.hit), 32'd0);
         check({tag, ".kill_pulse"}, 32'(bus.missile_kill), 32'd0);
         check({tag, ".busy_after"}, 32'(bus.busy), 32'd0);
`ifdef ALIEN_SCORE_EN
         check({tag, ".score"}, 32'(bus.score), 32'(m_score));
`endif
      end else begin
         check({tag, ".alien_hit_held"}, 32'(bus.alien_hit), 32'(m_last));
         check({tag, ".busy_idle"}, 32'(bus.busy), 32'd0);
      end
   endtask

   task automatic drop_active();
      bus.missile_active = 1'b0;
      @(posedge Clk);
      @(posedge Clk); #1;
      m_hold = 0;
      bus.missile_active = 1'b1;
   endtask

   initial begin
      Reset = 1'b1;
      bus.frame_tick = 1'b0;
      bus.missile_active = 1'b1;
      bus.missile_x = '0;
      bus.missile_y = '0;
      bus.alien_grid = '1;
      set_formation(100, 50);
      m_hold = 0;
      m_last = '0;
      m_score = 0;
      #12;
      check("rst.alien_hit", 32'(bus.alien_hit), 32'd0);
      check("rst.hit", 32'(bus.hit), 32'd0);
      check("rst.kill", 32'(bus.missile_kill), 32'd0);
      check("rst.busy", 32'(bus.busy), 32'd0);
      Reset = 1'b0;
      @(posedge Clk); #1;

      // Directed geometry cases
      shot("t1", 169, 77);
      check("t1.idx_const", 32'(bus.alien_hit), 32'h11);
      drop_active();
      shot("t2_gap", 158, 77);
      shot("gap_y", 169, 66);
      shot("t3_left", 90, 77);
      shot("t3_right", 420, 77);
      shot("row_ovf", 169, 194);
      shot("edge_far", 419, 185);
      drop_active();
      bus.alien_grid[2][1] = 1'b0;
      shot("t4_dead", 169, 77);
      shot("t4_row0", 169, 55);
      check("t4.idx_const", 32'(bus.alien_hit), 32'h10);
      drop_active();
      bus.alien_grid = '1;
      shot("t5_first", 169, 77);
      shot("t5_hold", 169, 77);
      drop_active();
      shot("t5_rearm", 169, 77);
      drop_active();

      // Reset while dividing: outputs clear at once, no hit follows
      bus.missile_x = 10'd419;
      bus.missile_y = 10'd77;
      bus.frame_tick = 1'b1;
      @(posedge Clk); #1;
      bus.frame_tick = 1'b0;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      check("t6.busy_before", 32'(bus.busy), 32'd1);
      #2 Reset = 1'b1;
      #1;
      check("t6.alien_hit", 32'(bus.alien_hit), 32'd0);
      check("t6.busy", 32'(bus.busy), 32'd0);
      check("t6.hit", 32'(bus.hit), 32'd0);
`ifdef ALIEN_SCORE_EN
      check("t6.score", 32'(bus.score), 32'd0);
`endif
      @(posedge Clk); #1;
      Reset = 1'b0;
      m_last = '0;
      m_score = 0;
      m_hold = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge Clk); #1;
         check("t6.no_hit", 32'(bus.hit), 32'd0);
      end
      shot("t6_row0", 169, 55);
      drop_active();

      for (int i = 0; i < 60; i++) begin
         set_formation($urandom_range(30, 400), $urandom_range(30, 300));
         for (int c = 0; c < 10; c++)
            for (int r = 0; r < 6; r++)
               bus.alien_grid[c][r] = ($urandom_range(0, 4) != 0);
         shot("rnd", fx - 20 + int'($urandom_range(0, 360)), fy - 10 + int'($urandom_range(0, 170)));
         if (m_hold && $urandom_range(0, 1) == 1)
            shot("rnd_hold", fx + int'($urandom_range(0, 300)), fy + int'($urandom_range(0, 140)));
         if (m_hold) drop_active();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
